tick_sched: RTL and testbench
=============================

TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 Parameter TICK_1MS, default 100_000, clock cycles per 1 ms base period (set small in simulation).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  level-sampled; begin run, or resume from PAUSE.
REQ-005 stop  input  1  level-sampled; abort to IDLE.
REQ-006 pause  input  1  level-sampled; freeze prescaler in RUN.
REQ-007 step  input  1  level-sampled; request one manual tick from IDLE or PAUSE.
REQ-008 dir  input  1  counting direction for the downstream reversible counter (1 = up).
REQ-009 period_sel  input  2  00=1 ms, 01=10 ms, 10=100 ms, 11=1 s.
REQ-010 burst_len  input  8  ticks per run; 0 = free-running.
REQ-011 tick  output  1  one-cycle count-enable pulse to the counter.
REQ-012 cnt_dir  output  1  dir sampled in the cycle that produced the current tick.
REQ-013 done  output  1  one-cycle pulse on burst completion.
REQ-014 busy  output  1  high whenever state is not IDLE.
REQ-015 state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, STEP=11.

Function
REQ-016 Period P = TICK_1MS x {1, 10, 100, 1000} for period_sel 00..11; 32-bit prescaler counts 0..P-1 and wraps to 0.
REQ-017 period_sel and burst_len shall be latched on entry to RUN from IDLE; period_sel is re-latched at each prescaler wrap; changes never truncate a period in progress.
REQ-018 Command priority when several are high in one cycle: stop > start > pause > step.
REQ-019 IDLE: start -> RUN with prescaler = 0 and burst count = 0; step -> STEP; otherwise hold; prescaler held at 0.
REQ-020 RUN: prescaler increments each cycle; on the wrap from P-1 to 0, tick = 1 in the following cycle; stop -> IDLE; pause -> PAUSE.
REQ-021 First tick after start is high exactly P cycles after the cycle in which start was sampled; subsequent ticks are exactly P cycles apart.
REQ-022 PAUSE: prescaler and burst count hold their values; start -> RUN, resuming from the held prescaler value; stop -> IDLE; step -> STEP.
REQ-023 STEP: tick = 1 for exactly one cycle, then unconditionally -> PAUSE; steps do not increment the burst count.
REQ-024 Burst (burst_len != 0): each RUN tick increments the burst count; the tick that makes the count equal burst_len asserts done in the same cycle, and the next state is IDLE.
REQ-025 Free run (latched burst_len = 0): the burst count saturates at 255; done is never asserted.
REQ-026 stop in the same cycle as a pending wrap suppresses that tick; done is not asserted.
REQ-027 A held level on start or step re-triggers only when the FSM revisits a state that accepts it; no edge detection is performed.
REQ-028 tick, done and cnt_dir are registered; no combinational path from inputs to outputs.

Reset
REQ-029 While rst = 1: state = IDLE, prescaler = 0, burst count = 0, latched period_sel = 00, latched burst_len = 0, tick = 0, done = 0, cnt_dir = 0, busy = 0.
REQ-030 rst asserted mid-run or mid-pause aborts immediately, with no tick or done pulse in the cycles that follow.

Structure
REQ-031 Shared package tick_sched_pkg shall hold the state encodings and the period multiplier constants {1, 10, 100, 1000}.
REQ-032 Prescaler implemented as sub-module tick_prescaler (inputs en, clr, P; output wrap); the FSM, burst logic and output registers remain in tick_sched.

Verification (TICK_1MS = 4)
REQ-033 Reset, then start with period_sel=00 and burst_len=0 -> ticks 4 cycles after start, then every 4 cycles; done stays 0.
REQ-034 burst_len=3, period_sel=01 -> three ticks 40 cycles apart; done coincides with the third tick; state = IDLE the next cycle.
REQ-035 pause 2 cycles into a period, held 10 cycles, then start -> next tick 2 cycles after resume; no tick during PAUSE.
REQ-036 step from IDLE -> single tick with state = 11, then state = 10; burst count unchanged.
REQ-037 start, stop and pause high together in RUN -> IDLE next cycle; a pending tick is suppressed.
REQ-038 rst pulsed one cycle before a wrap, with dir=1 -> no tick; all outputs 0; state = 00.

Source files
------------

// File: rtl/tick_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tick_sched_pkg
//  Purpose  : Shared definitions for the tick scheduler. Holds the FSM state
//             encodings, the period multiplier constants, and a helper that
//             turns a period selector into a prescaler length in clock cycles.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package tick_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_STEP  = 2'b11
  } state_t;

  // Base-period multipliers for period_sel = 00, 01, 10, 11.
  localparam logic [31:0] C_MULT_1MS   = 32'd1;
  localparam logic [31:0] C_MULT_10MS  = 32'd10;
  localparam logic [31:0] C_MULT_100MS = 32'd100;
  localparam logic [31:0] C_MULT_1S    = 32'd1000;

  // Number of clock cycles in one tick period for a given selector.
  function automatic logic [31:0] period_cycles(input logic [1:0]  sel,
                                                input logic [31:0] base);
    logic [31:0] mult;
    case (sel)
      2'b00:   mult = C_MULT_1MS;
      2'b01:   mult = C_MULT_10MS;
      2'b10:   mult = C_MULT_100MS;
      default: mult = C_MULT_1S;
    endcase
    return base * mult;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module   : tick_prescaler
//  Purpose  : 32-bit prescaler counting 0..period-1 while enabled. Flags the
//             cycle in which it wraps from period-1 back to 0.
//  Ports    : clk    - system clock
//             rst    - synchronous active-high reset
//             en     - advance the count this cycle
//             clr    - force the count to 0 (overrides en)
//             period - period length in cycles (must be >= 1)
//             wrap   - high in the cycle whose clock edge wraps the count
//  Revision : 1.0  initial release
// ============================================================================
module tick_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] period,
  output logic        wrap
);

  logic [31:0] r_count;

  assign wrap = en && !clr && (r_count == period - 32'd1);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= 32'd0;
    end else if (wrap) begin
      r_count <= 32'd0;
    end else if (en) begin
      r_count <= r_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tick_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tick_sched
//  Purpose  : Tick scheduler driving the count enable of a reversible counter.
//             Generates ticks every P cycles (P selectable 1 ms .. 1 s),
//             supports bursts of N ticks, pause/resume and manual steps.
//  Ports    : clk, rst              - clock, synchronous active-high reset
//             start, stop, pause,
//             step                  - level-sampled commands
//                                     (priority stop > start > pause > step)
//             dir                   - requested count direction (1 = up)
//             period_sel [1:0]      - 00=1ms 01=10ms 10=100ms 11=1s
//             burst_len  [7:0]      - ticks per run, 0 = free-running
//             tick                  - one-cycle count-enable pulse
//             cnt_dir               - dir captured with the current tick
//             done                  - one-cycle burst-complete pulse
//             busy                  - state is not IDLE
//             state [1:0]           - IDLE=00 RUN=01 PAUSE=10 STEP=11
//  Revision : 1.0  initial release
// ============================================================================
module tick_sched
  import tick_sched_pkg::*;
#(
  parameter int unsigned TICK_1MS = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       step,
  input  logic       dir,
  input  logic [1:0] period_sel,
  input  logic [7:0] burst_len,
  output logic       tick,
  output logic       cnt_dir,
  output logic       done,
  output logic       busy,
  output logic [1:0] state
);

  state_t      r_state;
  logic [1:0]  r_sel;
  logic [7:0]  r_len;
  logic [7:0]  r_burst_cnt;
  logic        r_tick;
  logic        r_done;
  logic        r_cnt_dir;

  logic        w_presc_en;
  logic        w_presc_clr;
  logic        w_wrap;
  logic [31:0] w_period;
  logic [7:0]  w_burst_next;

  assign w_period     = period_cycles(r_sel, 32'(TICK_1MS));
  assign w_burst_next = r_burst_cnt + 8'd1;

  // The prescaler only advances in RUN cycles that stay in RUN; a cycle that
  // is leaving for IDLE or PAUSE freezes it, which also swallows a pending wrap.
  // start outranks pause, so start held together with pause keeps running.
  assign w_presc_en  = (r_state == ST_RUN) && !stop && (start || !pause);
  assign w_presc_clr = (r_state == ST_IDLE);

  tick_prescaler u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (w_presc_en),
    .clr    (w_presc_clr),
    .period (w_period),
    .wrap   (w_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= 2'b00;
      r_len       <= 8'd0;
      r_burst_cnt <= 8'd0;
      r_tick      <= 1'b0;
      r_done      <= 1'b0;
      r_cnt_dir   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;

      // New period length takes effect only from the next period onwards.
      if (w_wrap) begin
        r_sel <= period_sel;
      end

      case (r_state)
        ST_IDLE: begin
          if (stop) begin
            r_state <= ST_IDLE;
          end else if (start) begin
            r_state     <= ST_RUN;
            r_burst_cnt <= 8'd0;
            r_sel       <= period_sel;
            r_len       <= burst_len;
          end else if (step) begin
            r_state   <= ST_STEP;
            r_tick    <= 1'b1;
            r_cnt_dir <= dir;
          end
        end

        ST_RUN: begin
          if (stop) begin
            r_state <= ST_IDLE;
          end else if (w_wrap) begin
            r_tick    <= 1'b1;
            r_cnt_dir <= dir;
            if (r_len == 8'd0) begin
              if (r_burst_cnt != 8'hFF) begin
                r_burst_cnt <= w_burst_next;
              end
            end else begin
              r_burst_cnt <= w_burst_next;
              if (w_burst_next == r_len) begin
                r_done  <= 1'b1;
                r_state <= ST_IDLE;
              end
            end
          end else if (!start && pause) begin
            r_state <= ST_PAUSE;
          end
        end

        ST_PAUSE: begin
          if (stop) begin
            r_state <= ST_IDLE;
          end else if (start) begin
            r_state <= ST_RUN;
          end else if (pause) begin
            r_state <= ST_PAUSE;
          end else if (step) begin
            r_state   <= ST_STEP;
            r_tick    <= 1'b1;
            r_cnt_dir <= dir;
          end
        end

        ST_STEP: begin
          r_state <= ST_PAUSE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tick    = r_tick;
  assign done    = r_done;
  assign cnt_dir = r_cnt_dir;
  assign busy    = (r_state != ST_IDLE);
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tick_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tick_sched
//  Purpose  : Self-checking bench for tick_sched with TICK_1MS = 4.
//             Directed vector table, hand-written corner sequences, and a
//             randomized run compared against a behavioural model.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_tick_sched;

  localparam int unsigned TICK_1MS = 4;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic       step;
  logic       dir;
  logic [1:0] period_sel;
  logic [7:0] burst_len;
  logic       tick;
  logic       cnt_dir;
  logic       done;
  logic       busy;
  logic [1:0] state;

  tick_sched #(.TICK_1MS(TICK_1MS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .step       (step),
    .dir        (dir),
    .period_sel (period_sel),
    .burst_len  (burst_len),
    .tick       (tick),
    .cnt_dir    (cnt_dir),
    .done       (done),
    .busy       (busy),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Apply one cycle of inputs, clock once, settle 1 time unit past the edge.
  task automatic cyc(input bit r, sa, so, pa, sp, d, input logic [1:0] sel, input logic [7:0] len);
    rst = r; start = sa; stop = so; pause = pa; step = sp; dir = d;
    period_sel = sel; burst_len = len;
    @(posedge clk);
    #1;
  endtask

  // Observed outputs packed as {state, busy, tick, done, cnt_dir}.
  function automatic logic [5:0] obs();
    return {state, busy, tick, done, cnt_dir};
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r, sa, so, pa, sp, d;
    logic [1:0] sel;
    logic [7:0] len;
    logic [1:0] e_st;
    bit e_tick, e_done, e_busy, e_dir;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, sa, so, pa, sp, d, input logic [1:0] sel, input logic [7:0] len,
                     input logic [1:0] e_st, input bit e_tick, e_done, e_busy, e_dir);
    vec_t v;
    v.r = r; v.sa = sa; v.so = so; v.pa = pa; v.sp = sp; v.d = d;
    v.sel = sel; v.len = len;
    v.e_st = e_st; v.e_tick = e_tick; v.e_done = e_done; v.e_busy = e_busy; v.e_dir = e_dir;
    vq.push_back(v);
  endtask

  // ---------------- behavioural reference model ----------------
  int m_st, m_ph, m_P, m_len, m_cnt;
  bit m_tick, m_done, m_dir;

  function automatic int ref_period(input int sel);
    int mult;
    mult = (sel == 0) ? 1 : (sel == 1) ? 10 : (sel == 2) ? 100 : 1000;
    return TICK_1MS * mult;
  endfunction

  task automatic model_step(input bit r, sa, so, pa, sp, d, input int sel, len);
    m_tick = 0;
    m_done = 0;
    if (r) begin
      m_st = 0; m_ph = 0; m_P = ref_period(0); m_len = 0; m_cnt = 0; m_dir = 0;
      return;
    end
    case (m_st)
      0: begin
        if (so) m_st = 0;
        else if (sa) begin
          m_st = 1; m_ph = 0; m_P = ref_period(sel); m_len = len; m_cnt = 0;
        end else if (sp) begin
          m_st = 3; m_tick = 1; m_dir = d;
        end
      end
      1: begin
        if (so) begin
          m_st = 0; m_ph = 0;
        end else if (sa || !pa) begin
          m_ph++;
          if (m_ph == m_P) begin
            m_ph = 0; m_P = ref_period(sel); m_tick = 1; m_dir = d;
            if (m_len == 0) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            else begin
              m_cnt = (m_cnt + 1) % 256;
              if (m_cnt == m_len) begin
                m_done = 1; m_st = 0;
              end
            end
          end
        end else m_st = 2;
      end
      2: begin
        if (so) begin
          m_st = 0; m_ph = 0;
        end else if (sa) m_st = 1;
        else if (pa) m_st = 2;
        else if (sp) begin
          m_st = 3; m_tick = 1; m_dir = d;
        end
      end
      default: m_st = 2;
    endcase
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; pause = 0; step = 0; dir = 0;
    period_sel = 2'b00; burst_len = 8'd0;

    // Free run at P=4, dir change, pause/resume, stop, step from IDLE.
    add(1,0,0,0,0,1, 2'd0, 8'd0, 2'd0, 0,0,0,0);
    add(0,0,0,0,0,1, 2'd0, 8'd0, 2'd0, 0,0,0,0);
    add(0,1,0,0,0,1, 2'd0, 8'd0, 2'd1, 0,0,1,0);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,1, 2'd0, 8'd0, 2'd1, 0,0,1,0);
    add(0,0,0,0,0,1, 2'd0, 8'd0, 2'd1, 1,0,1,1);
    for (int i = 0; i < 3; i++) add(0,0,0,0,0,1, 2'd0, 8'd0, 2'd1, 0,0,1,1);
    add(0,0,0,0,0,0, 2'd0, 8'd0, 2'd1, 1,0,1,0);
    for (int i = 0; i < 2; i++) add(0,0,0,0,0,0, 2'd0, 8'd0, 2'd1, 0,0,1,0);
    for (int i = 0; i < 10; i++) add(0,0,0,1,0,0, 2'd0, 8'd0, 2'd2, 0,0,1,0);
    add(0,1,0,0,0,0, 2'd0, 8'd0, 2'd1, 0,0,1,0);
    add(0,0,0,0,0,0, 2'd0, 8'd0, 2'd1, 0,0,1,0);
    add(0,0,0,0,0,0, 2'd0, 8'd0, 2'd1, 1,0,1,0);
    add(0,0,1,0,0,0, 2'd0, 8'd0, 2'd0, 0,0,0,0);
    add(0,0,0,0,1,1, 2'd0, 8'd0, 2'd3, 1,0,1,1);
    add(0,0,0,0,0,1, 2'd0, 8'd0, 2'd2, 0,0,1,1);
    add(0,0,1,0,0,1, 2'd0, 8'd0, 2'd0, 0,0,0,1);

    foreach (vq[i]) begin
      cyc(vq[i].r, vq[i].sa, vq[i].so, vq[i].pa, vq[i].sp, vq[i].d, vq[i].sel, vq[i].len);
      chk($sformatf("vec%0d", i), 32'(obs()),
          32'({vq[i].e_st, vq[i].e_busy, vq[i].e_tick, vq[i].e_done, vq[i].e_dir}));
    end

    // Burst of 3 at 10 ms (40 cycles): done with the third tick, then IDLE.
    cyc(1,0,0,0,0,0, 2'd0, 8'd0);
    cyc(0,1,0,0,0,0, 2'd1, 8'd3);
    for (int n = 1; n <= 130; n++) begin
      cyc(0,0,0,0,0,0, 2'd1, 8'd3);
      chk($sformatf("burst_n%0d", n), 32'({state, tick, done}),
          32'({(n < 120) ? 2'd1 : 2'd0, (n % 40 == 0) && (n <= 120), n == 120}));
    end

    // start+stop+pause together on the wrap cycle: IDLE, tick suppressed.
    cyc(0,1,0,0,0,0, 2'd0, 8'd0);
    for (int n = 1; n <= 3; n++) cyc(0,0,0,0,0,0, 2'd0, 8'd0);
    cyc(0,1,1,1,0,0, 2'd0, 8'd0);
    chk("triple_cmd", 32'({state, busy, tick, done}), 32'(5'b00000));
    cyc(0,0,0,0,0,0, 2'd0, 8'd0);
    chk("triple_after", 32'({state, busy, tick, done}), 32'(5'b00000));

    // rst one cycle before a wrap with dir=1: everything back to zero.
    cyc(0,1,0,0,0,1, 2'd0, 8'd0);
    for (int n = 1; n <= 3; n++) cyc(0,0,0,0,0,1, 2'd0, 8'd0);
    cyc(1,0,0,0,0,1, 2'd0, 8'd0);
    chk("rst_wrap", 32'(obs()), 32'(6'b000000));
    for (int n = 0; n < 4; n++) begin
      cyc(0,0,0,0,0,1, 2'd0, 8'd0);
      chk($sformatf("rst_after%0d", n), 32'(obs()), 32'(6'b000000));
    end

    // Randomized run against the reference model.
    cyc(1,0,0,0,0,0, 2'd0, 8'd0);
    model_step(1,0,0,0,0,0, 0, 0);
    for (int n = 0; n < 4000; n++) begin
      bit r, sa, so, pa, sp, d;
      int sel, len;
      r   = ($urandom_range(0, 299) == 0);
      sa  = ($urandom_range(0, 9) == 0);
      so  = ($urandom_range(0, 39) == 0);
      pa  = ($urandom_range(0, 7) == 0);
      sp  = ($urandom_range(0, 7) == 0);
      d   = 1'($urandom_range(0, 1));
      sel = ($urandom_range(0, 9) == 0) ? 1 : 0;
      len = $urandom_range(0, 4);
      cyc(r, sa, so, pa, sp, d, 2'(sel), 8'(len));
      model_step(r, sa, so, pa, sp, d, sel, len);
      chk($sformatf("rand%0d", n), 32'(obs()),
          32'({2'(m_st), m_st != 0, m_tick, m_done, m_dir}));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
